// File: rtl/riscv_pkg.sv
// Shared core definitions: opcode map, fetch FSM states and reset constants.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_t;

endpackage

// File: rtl/riscv_ifu_if.sv
// Fetch-unit bus: instruction-memory request/response plus the decode handshake.
interface riscv_ifu_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;

  // master: the fetch unit
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );

  // slave: memory and decode side
  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );
endinterface

// File: rtl/riscv_ifu.sv
// Instruction fetch unit: owns the PC, keeps one imem request in flight and
// holds the fetched word for decode; execute redirects squash in-flight fetches.
module riscv_ifu
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  riscv_ifu_if.master     bus
);

  ifu_state_t      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            vld_q, vld_d;
  logic [XLEN-1:0] ifpc_q, ifpc_d;
  logic [31:0]     instr_q, instr_d;

  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] pc_inc;
  logic            req_hs;

  assign redir_pc = redirect_pc & ~XLEN'(3);
  assign pc_inc   = pc_q + XLEN'(4);
  assign req_hs   = (state_q == S_REQ) && bus.imem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      vld_q   <= 1'b0;
      ifpc_q  <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      vld_q   <= vld_d;
      ifpc_q  <= ifpc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    vld_d   = vld_q;
    ifpc_d  = ifpc_q;
    instr_d = instr_q;
    unique case (state_q)
      S_REQ: begin
        // unaccepted address may retarget; accepted one becomes stale
        if (redirect_valid) pc_d = redir_pc;
        if (req_hs) begin
          state_d = S_WAIT;
          drop_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          state_d = S_REQ;
          drop_d  = 1'b0;
          if (redirect_valid) begin
            pc_d = redir_pc;
          end else if (!drop_q) begin
            instr_d = bus.imem_rsp_data;
            ifpc_d  = pc_q;
            vld_d   = 1'b1;
            pc_d    = pc_inc;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          pc_d   = redir_pc;
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid || bus.if_ready) begin
          vld_d   = 1'b0;
          state_d = S_REQ;
          if (redirect_valid) pc_d = redir_pc;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = vld_q;
  assign bus.if_pc          = ifpc_q;
  assign bus.if_instr       = instr_q;

endmodule

// File: tb/tb_riscv_ifu.sv
// Fetch unit bench: directed scenarios then random memory/decode/redirect
// traffic, checked every cycle against a transaction-level model.
module tb_riscv_ifu;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  riscv_ifu_if #(.XLEN(32)) bus();

  riscv_ifu #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model: what the fetch unit is doing, in transaction terms
  logic [31:0] m_pc, m_ifpc, m_instr;
  bit          m_want;   // wants to issue a request
  bit          m_fly;    // a request has been accepted, response pending
  bit          m_stale;  // that pending response must be thrown away
  bit          m_held;   // decode is being offered an instruction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [31:0] tgt;
    tgt = {redirect_pc[31:2], 2'b00};
    if (rst) begin
      m_pc = 32'h8000_0000; m_ifpc = 32'h0; m_instr = NOP_INSTR;
      m_want = 1; m_fly = 0; m_stale = 0; m_held = 0;
    end else if (m_want) begin
      if (bus.imem_req_ready) begin
        m_want = 0; m_fly = 1; m_stale = redirect_valid;
      end
      if (redirect_valid) m_pc = tgt;
    end else if (m_fly) begin
      if (bus.imem_rsp_valid) begin
        m_fly = 0;
        if (redirect_valid) begin
          m_pc = tgt; m_want = 1;
        end else if (m_stale) begin
          m_want = 1;
        end else begin
          m_ifpc = m_pc; m_instr = bus.imem_rsp_data; m_held = 1;
          m_pc = m_pc + 32'd4;
        end
        m_stale = 0;
      end else if (redirect_valid) begin
        m_pc = tgt; m_stale = 1;
      end
    end else if (m_held) begin
      if (redirect_valid || bus.if_ready) begin
        m_held = 0; m_want = 1;
        if (redirect_valid) m_pc = tgt;
      end
    end
  endtask

  task automatic step(bit r, bit rv, logic [31:0] rpc, bit rdy, bit rspv,
                      logic [31:0] rspd, bit ifr);
    rst = r; redirect_valid = rv; redirect_pc = rpc;
    bus.imem_req_ready = rdy; bus.imem_rsp_valid = rspv;
    bus.imem_rsp_data = rspd; bus.if_ready = ifr;
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("req_valid", 32'(bus.imem_req_valid), 32'(m_want));
    chk("req_addr",  bus.imem_req_addr, m_pc);
    chk("if_valid",  32'(bus.if_valid), 32'(m_held));
    chk("if_pc",     bus.if_pc, m_ifpc);
    chk("if_instr",  bus.if_instr, m_instr);
  endtask

  task automatic idle(bit ifr);
    step(0, 0, 32'h0, 0, 0, 32'h0, ifr);
  endtask

  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_data;

  initial begin
    rst = 1; redirect_valid = 0; redirect_pc = 0;
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0;
    bus.imem_rsp_data = 0; bus.if_ready = 0;
    m_pc = 0; m_ifpc = 0; m_instr = 0;
    m_want = 0; m_fly = 0; m_stale = 0; m_held = 0;
    @(negedge clk);

    // 1: zero-wait fetch
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t1_rst_instr", bus.if_instr, 32'h0000_0013);
    chk("t1_req_addr", bus.imem_req_addr, 32'h8000_0000);
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1, 32'h0010_0093, 1);
    chk("t1_if_pc", bus.if_pc, 32'h8000_0000);
    chk("t1_if_instr", bus.if_instr, 32'h0010_0093);
    idle(1);
    chk("t1_next_addr", bus.imem_req_addr, 32'h8000_0004);

    // 2: decode stall in hold
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h0020_0113, 0);
    for (int i = 0; i < 5; i++) begin
      idle(0);
      chk("t2_hold_vld", 32'(bus.if_valid), 32'd1);
      chk("t2_hold_instr", bus.if_instr, 32'h0020_0113);
    end
    idle(1);
    chk("t2_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t2_next_addr", bus.imem_req_addr, 32'h8000_0004);

    // 3: redirect while waiting, late response is dropped
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 1, 32'h8000_0100, 0, 0, 0, 1);
    idle(1);
    idle(1);
    step(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1);
    chk("t3_if_valid", 32'(bus.if_valid), 32'd0);
    chk("t3_next_addr", bus.imem_req_addr, 32'h8000_0100);

    // 4: redirect together with the response, misaligned target
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 1, 32'h8000_0203, 0, 1, 32'h1234_5678, 1);
    chk("t4_if_valid", 32'(bus.if_valid), 32'd0);
    chk("t4_next_addr", bus.imem_req_addr, 32'h8000_0200);

    // 5: PC wrap
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1, 32'h0000_006F, 1);
    chk("t5_if_pc", bus.if_pc, 32'hFFFF_FFFC);
    idle(1);
    chk("t5_next_addr", bus.imem_req_addr, 32'h0000_0000);

    // 6: reset mid-fetch, stale response afterwards
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 32'hBAD0_0BAD, 1);
    chk("t6_if_valid", 32'(bus.if_valid), 32'd0);
    chk("t6_if_instr", bus.if_instr, 32'h0000_0013);
    chk("t6_req_addr", bus.imem_req_addr, 32'h8000_0000);

    // random traffic; memory answers 1..4 cycles after acceptance
    mem_busy = 0; mem_cnt = 0; mem_data = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      bit          r, rv, rdy, rspv, ifr, acc;
      logic [31:0] rpc;
      r    = ($urandom_range(0, 199) == 0);
      rv   = ($urandom_range(0, 7) == 0);
      rpc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFE : $urandom;
      rdy  = ($urandom_range(0, 3) != 0);
      ifr  = ($urandom_range(0, 2) != 0);
      rspv = mem_busy && (mem_cnt == 0);
      acc  = m_want && rdy && !r;
      step(r, rv, rpc, rdy, rspv, mem_data, ifr);
      if (r || rspv) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (acc) begin
        mem_busy = 1;
        mem_cnt  = $urandom_range(0, 3);
        mem_data = $urandom;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
